// File: rtl/parity_pkg.sv
// Shared definitions for the parity serializer and its matching serial checker.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/parity_shifter.sv
// Datapath for the serializer: LSB-first shift register, bit counter and running parity.
module parity_shifter #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  seed_i,
    output logic                  bit_o,
    output logic                  parity_o,
    output logic                  last_bit_o
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  acc_q, acc_d;

    // Load takes priority so a reload in the parity slot starts the next frame cleanly.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (load_i) begin
            sr_d  = data_i;
            cnt_d = '0;
            acc_d = seed_i;
        end else if (shift_i) begin
            sr_d  = {1'b0, sr_q[DATA_WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = acc_q ^ sr_q[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
            acc_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    assign bit_o      = sr_q[0];
    assign parity_o   = acc_q;
    assign last_bit_o = (cnt_q == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/parity_serializer.sv
// Parallel-to-serial transmitter: DATA_WIDTH bits LSB first, then one parity bit.
module parity_serializer
    import parity_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ODD_PARITY = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  output_bit,
    output logic                  frame_active,
    output logic                  parity_slot
);

    localparam logic SEED = (ODD_PARITY != 0) ? PARITY_ODD : PARITY_EVEN;

    state_e state_q, state_d;
    logic   accept_c;
    logic   load_c;
    logic   shift_c;
    logic   sh_bit;
    logic   sh_parity;
    logic   sh_last;

    assign in_ready = (state_q == IDLE) || (state_q == PARITY);
    assign accept_c = in_valid && in_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = DATA;
            DATA:    if (sh_last)  state_d = PARITY;
            PARITY:  state_d = accept_c ? DATA : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Line outputs decode only flop state, so no input reaches them combinationally.
    always_comb begin
        output_bit   = 1'b0;
        frame_active = 1'b0;
        parity_slot  = 1'b0;
        load_c       = 1'b0;
        shift_c      = 1'b0;
        case (state_q)
            IDLE: begin
                load_c = accept_c;
            end
            DATA: begin
                output_bit   = sh_bit;
                frame_active = 1'b1;
                shift_c      = 1'b1;
            end
            PARITY: begin
                output_bit   = sh_parity;
                frame_active = 1'b1;
                parity_slot  = 1'b1;
                load_c       = accept_c;
            end
            default: begin
                output_bit = 1'b0;
            end
        endcase
    end

    parity_shifter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shifter (
        .clk        (clock),
        .rst_n      (reset),
        .load_i     (load_c),
        .shift_i    (shift_c),
        .data_i     (in_data),
        .seed_i     (SEED),
        .bit_o      (sh_bit),
        .parity_o   (sh_parity),
        .last_bit_o (sh_last)
    );

endmodule

// File: tb/tb_parity_serializer.sv
// Scoreboard bench: even- and odd-parity serializers driven in lockstep, line checked every cycle.
module tb_parity_serializer;

    typedef struct packed {
        logic flip;
        logic slot;
        logic b;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       rdy_e, ob_e, fa_e, ps_e;
    logic       rdy_o, ob_o, fa_o, ps_o;

    exp_t q_e[$];
    exp_t q_o[$];
    logic rx_acc[2];
    int   vectors;
    int   miscompares;

    parity_serializer #(.DATA_WIDTH(8), .ODD_PARITY(0)) dut_e (
        .clock        (clk),
        .reset        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (rdy_e),
        .output_bit   (ob_e),
        .frame_active (fa_e),
        .parity_slot  (ps_e)
    );

    parity_serializer #(.DATA_WIDTH(8), .ODD_PARITY(1)) dut_o (
        .clock        (clk),
        .reset        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (rdy_o),
        .output_bit   (ob_o),
        .frame_active (fa_o),
        .parity_slot  (ps_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected line for one frame; the flip flag marks a frame whose bit 0 the loopback corrupts.
    task automatic push(input logic [7:0] w, input logic flip);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            q_e.push_back('{flip: flip && (i == 0), slot: 1'b0, b: w[i]});
            q_o.push_back('{flip: flip && (i == 0), slot: 1'b0, b: w[i]});
            acc = acc ^ w[i];
        end
        q_e.push_back('{flip: flip, slot: 1'b1, b: acc});
        q_o.push_back('{flip: flip, slot: 1'b1, b: ~acc});
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] w, input logic flip);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int t = 0; t < 40 && !done; t++) begin
            if (rdy_e) begin
                push(w, flip);
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) check("accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic mon(input int d, input logic have, input exp_t e,
                       input logic ob, input logic fa, input logic ps, input logic rdy);
        logic line;
        logic err;
        check($sformatf("frame_active%0d", d), fa, have);
        check($sformatf("parity_slot%0d", d), ps, have && e.slot);
        check($sformatf("output_bit%0d", d), ob, have ? e.b : 1'b0);
        check($sformatf("in_ready%0d", d), rdy, !(have && !e.slot));
        if (have) begin
            if (!e.slot) begin
                line      = ob ^ e.flip;
                rx_acc[d] = rx_acc[d] ^ line;
            end else begin
                err = rx_acc[d] ^ ob ^ (d == 1);
                check($sformatf("loop_err%0d", d), err, e.flip);
                rx_acc[d] = 1'b0;
            end
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        logic have;
        #3;
        if (rst_n) begin
            have = (q_e.size() > 0);
            e    = have ? q_e.pop_front() : exp_t'(3'b000);
            mon(0, have, e, ob_e, fa_e, ps_e, rdy_e);
            have = (q_o.size() > 0);
            e    = have ? q_o.pop_front() : exp_t'(3'b000);
            mon(1, have, e, ob_o, fa_o, ps_o, rdy_o);
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rx_acc[0]   = 1'b0;
        rx_acc[1]   = 1'b0;
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        #2 rst_n = 1'b0;
        #2;
        check("rst_ready", rdy_e, 1'b1);
        check("rst_line", ob_e, 1'b0);
        check("rst_active", fa_e, 1'b0);
        check("rst_slot_odd", ps_o, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send(8'hA5, 1'b0);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);

        send(8'h07, 1'b0);
        send(8'hFF, 1'b0);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);

        send(8'h00, 1'b0);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        send(8'h01, 1'b0);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);

        // Abort A5 while its fourth data bit is on the line.
        send(8'hA5, 1'b0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_line_e", ob_e, 1'b0);
        check("abort_active_e", fa_e, 1'b0);
        check("abort_line_o", ob_o, 1'b0);
        check("abort_active_o", fa_o, 1'b0);
        check("abort_ready", rdy_e, 1'b1);
        q_e.delete();
        q_o.delete();
        rx_acc[0] = 1'b0;
        rx_acc[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h3C, 1'b0);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 100; i++) begin
            send(8'($urandom), 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                repeat ($urandom_range(1, 12)) @(negedge clk);
            end
        end
        for (int i = 0; i < 10; i++) begin
            send(8'($urandom), 1'b1);
        end
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        check("drain_e", q_e.size() == 0, 1'b1);
        check("drain_o", q_o.size() == 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
